busy_arbiter: RTL and testbench
===============================

BUSY_ARBITER -- requirements
Module: busy_arbiter

Interface
REQ-001 Parameter SLOT_MAX, default 64, maximum grant length in clock cycles; legal range 2..1023.
REQ-002 Parameter GAP, default 1, number of all-idle cycles between grants; legal range 1..15.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_1..req_5  input  1 each  access requests; 1-4 are word formers, 5 is MCM.
REQ-006 done_1..done_5  input  1 each  early release from the granted client.
REQ-007 busy_1..busy_5  output  1 each  registered grant strobes; at most one SHALL be high.
REQ-008 grant_id  output  3  granted client 1..5; 0 when none is granted.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked at SLOT_MAX.
REQ-010 timeout_id  output  3  client revoked by the last timeout; held until the next timeout.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-012 IDLE: if any req_k is high at edge N, the arbiter SHALL select a winner, and busy_winner and grant_id SHALL be high from edge N+1. Otherwise the FSM SHALL stay in IDLE.
REQ-013 Round-robin selection: after a grant to client k, search order SHALL start at k+1 and wrap from 5 to 1.
REQ-014 GRANT: busy_k SHALL hold and a 10-bit slot counter SHALL increment each cycle starting from 0.
REQ-015 Exit from GRANT SHALL occur on done_k sampled high; busy_k SHALL then go low at the next edge and the FSM SHALL enter GAP.
REQ-016 Exit from GRANT SHALL also occur when the counter equals SLOT_MAX-1 and done_k is low; busy_k SHALL drop at the next edge, timeout SHALL pulse for one cycle at that same edge, and timeout_id SHALL be set to k.
REQ-017 If done_k and the counter limit coincide, the exit SHALL be treated as done and no timeout SHALL be raised.
REQ-018 Inputs done_j for j≠k, and any deassertion of req_k during GRANT, SHALL be ignored.
REQ-019 GAP: all busy outputs and grant_id SHALL be 0 for exactly GAP cycles, then the FSM SHALL return to IDLE. This guarantees the downstream mux sees all-zero triggers between owners.
REQ-020 Minimum turnaround SHALL be busy low for GAP+1 cycles before the next busy goes high.
REQ-021 A requester that holds req continuously SHALL be granted within 4 foreign grants.

Reset
REQ-022 While reset is low at an edge, the outputs SHALL take these values: busy_1..5=0, grant_id=0, timeout=0, timeout_id=0; the FSM SHALL be in IDLE, the counter at 0, and the round-robin pointer set so that client 1 has highest priority.
REQ-023 A reset asserted during GRANT or GAP SHALL abort the operation with no timeout pulse.

Configuration
REQ-024 Macro BUSY_ARBITER_MCM_PRIORITY_EN. When defined, req_5 SHALL win over any request in IDLE and the round-robin pointer SHALL NOT advance after an MCM grant. When undefined, all five clients SHALL be in plain round-robin.

Structure
REQ-025 Package distributor_pkg SHALL hold: the client count (5), the grant_id encoding, the FSM state enum, and the counter width (10).
REQ-026 Round-robin selection SHALL be a sub-module rr_picker: inputs are the 5-bit request vector and the pointer; outputs are a one-hot winner and a valid flag. It SHALL be combinational and instantiated once.

Verification
REQ-027 Scenario: reset released; req_3=1 at edge 5 -> busy_3=1 and grant_id=3 from edge 6; done_3 at edge 9 -> busy_3=0 at edge 10; idle for 1 cycle.
REQ-028 Scenario: req_1..req_4 all held high, no MCM -> grant order 1,2,3,4,1; each grant separated by GAP=1 zero cycle.
REQ-029 Scenario: req_2 held, done_2 never asserted, SLOT_MAX=64 -> busy_2 high for exactly 64 cycles; timeout pulses once; timeout_id=2.
REQ-030 Scenario: done_2 and counter=63 in the same cycle -> no timeout pulse, and timeout_id keeps its previous value.
REQ-031 Scenario: macro defined, req_1 and req_5 raised together -> client 5 granted first, then client 1. Macro undefined after reset -> client 1 granted first.
REQ-032 Scenario: reset pulled low mid-grant of client 4 -> all busy=0 at the next edge and no timeout; the next arbitration starts from client 1.

Source files
------------

// File: rtl/distributor_pkg.sv
// Shared definitions for the busy_arbiter slice.
//
// Contents:
//   NUM_CLIENTS   number of requesters (4 word formers + 1 MCM)
//   CNT_W         width of the grant slot counter
//   GID_NONE      grant_id value when nobody owns the bus
//   MCM_ID        grant_id of the MCM client
//   state_e       arbiter FSM state encoding (also driven on dbg_state)
//   onehot_to_id  one-hot client vector -> grant_id (1..5, 0 = none)
//   next_ptr      round-robin pointer (0-based index) following a grant
package distributor_pkg;

    localparam int NUM_CLIENTS = 5;
    localparam int CNT_W       = 10;

    // grant_id encoding: client k is reported as k, no owner is 0.
    localparam logic [2:0] GID_NONE = 3'd0;
    localparam logic [2:0] MCM_ID   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic [2:0] onehot_to_id(input logic [NUM_CLIENTS-1:0] oh);
        logic [2:0] id;
        id = GID_NONE;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (oh[i]) id = 3'(i + 1);
        end
        return id;
    endfunction

    // Client k sits at index k-1, so the client after k sits at index k,
    // wrapping from client 5 back to index 0 (client 1).
    function automatic logic [2:0] next_ptr(input logic [2:0] id);
        return (id == MCM_ID) ? 3'd0 : id;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//
// Ports:
//   req_i    [4:0]  request vector, bit i = client i+1
//   ptr_i    [2:0]  index of the client with highest priority (0..4)
//   winner_o [4:0]  one-hot winner, all zero when no request
//   valid_o         high when any request is present
module rr_picker
    import distributor_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [2:0]             ptr_i,
    output logic [NUM_CLIENTS-1:0] winner_o,
    output logic                   valid_o
);

    logic [3:0] idx;

    // Walk the clients starting at ptr_i, wrapping modulo NUM_CLIENTS;
    // the first requester found wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            idx = {1'b0, ptr_i} + 4'(i);
            if (idx >= 4'(NUM_CLIENTS)) idx = idx - 4'(NUM_CLIENTS);
            if (!valid_o && req_i[idx[2:0]]) begin
                winner_o[idx[2:0]] = 1'b1;
                valid_o            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/busy_arbiter.sv
// Five-client bus arbiter with bounded grant slots and a guaranteed
// all-idle gap between owners.
//
// Parameters:
//   SLOT_MAX  maximum grant length in cycles (2..1023)
//   GAP       all-idle cycles after each grant (1..15)
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous, active-low reset
//   req_1..req_5         requests (1-4 word formers, 5 = MCM)
//   done_1..done_5       early release from the current owner
//   busy_1..busy_5       registered grant strobes, at most one high
//   grant_id    [2:0]    current owner 1..5, 0 when none
//   timeout              one-cycle pulse when a grant hits SLOT_MAX
//   timeout_id  [2:0]    client revoked by the last timeout
//   dbg_state   [1:0]    FSM state (distributor_pkg::state_e)
//
// Configuration:
//   BUSY_ARBITER_MCM_PRIORITY_EN  when defined, req_5 wins any IDLE
//   arbitration and an MCM grant leaves the round-robin pointer alone.
//   When undefined all five clients share plain round-robin.
module busy_arbiter
    import distributor_pkg::*;
#(
    parameter int SLOT_MAX = 64,
    parameter int GAP      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_1,
    input  logic       req_2,
    input  logic       req_3,
    input  logic       req_4,
    input  logic       req_5,
    input  logic       done_1,
    input  logic       done_2,
    input  logic       done_3,
    input  logic       done_4,
    input  logic       done_5,
    output logic       busy_1,
    output logic       busy_2,
    output logic       busy_3,
    output logic       busy_4,
    output logic       busy_5,
    output logic [2:0] grant_id,
    output logic       timeout,
    output logic [2:0] timeout_id,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_MAX - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP - 1);

    logic [NUM_CLIENTS-1:0] req_vec;
    logic [NUM_CLIENTS-1:0] done_vec;

    assign req_vec  = {req_5, req_4, req_3, req_2, req_1};
    assign done_vec = {done_5, done_4, done_3, done_2, done_1};

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [3:0]             gap_cnt_q;
    logic [2:0]             ptr_q;
    logic [NUM_CLIENTS-1:0] busy_q;
    logic [2:0]             grant_id_q;
    logic                   timeout_q;
    logic [2:0]             timeout_id_q;

    logic [NUM_CLIENTS-1:0] rr_winner;
    logic                   rr_valid;

    rr_picker u_rr_picker (
        .req_i    (req_vec),
        .ptr_i    (ptr_q),
        .winner_o (rr_winner),
        .valid_o  (rr_valid)
    );

    // Final arbitration result and whether the pointer should move.
    logic [NUM_CLIENTS-1:0] sel_winner;
    logic                   sel_valid;
    logic                   sel_advance;

    always_comb begin
        sel_winner  = rr_winner;
        sel_valid   = rr_valid;
        sel_advance = 1'b1;
`ifdef BUSY_ARBITER_MCM_PRIORITY_EN
        if (req_5) begin
            sel_winner  = 5'b10000;
            sel_valid   = 1'b1;
            sel_advance = 1'b0;
        end
`endif
    end

    // busy_q is one-hot on the owner, so masking selects done_k only and
    // done from any other client is ignored.
    logic done_hit;
    assign done_hit = |(busy_q & done_vec);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gap_cnt_q    <= '0;
            ptr_q        <= 3'd0;
            busy_q       <= '0;
            grant_id_q   <= GID_NONE;
            timeout_q    <= 1'b0;
            timeout_id_q <= GID_NONE;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        busy_q     <= sel_winner;
                        grant_id_q <= onehot_to_id(sel_winner);
                        cnt_q      <= '0;
                        state_q    <= ST_GRANT;
                        if (sel_advance) ptr_q <= next_ptr(onehot_to_id(sel_winner));
                    end
                end
                ST_GRANT: begin
                    // done wins over the slot limit when both land together.
                    if (done_hit) begin
                        busy_q     <= '0;
                        grant_id_q <= GID_NONE;
                        cnt_q      <= '0;
                        gap_cnt_q  <= '0;
                        state_q    <= ST_GAP;
                    end else if (cnt_q == CNT_LAST) begin
                        busy_q       <= '0;
                        grant_id_q   <= GID_NONE;
                        cnt_q        <= '0;
                        gap_cnt_q    <= '0;
                        timeout_q    <= 1'b1;
                        timeout_id_q <= grant_id_q;
                        state_q      <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_1     = busy_q[0];
    assign busy_2     = busy_q[1];
    assign busy_3     = busy_q[2];
    assign busy_4     = busy_q[3];
    assign busy_5     = busy_q[4];
    assign grant_id   = grant_id_q;
    assign timeout    = timeout_q;
    assign timeout_id = timeout_id_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_busy_arbiter.sv
// Directed bench for busy_arbiter: expected grant owners are queued when
// requests are raised and popped as each grant appears on the outputs.
module tb_busy_arbiter;

    localparam int SLOT_MAX = 64;
    localparam int GAP      = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:1] req;
    logic [5:1] done;
    logic       busy_1, busy_2, busy_3, busy_4, busy_5;
    logic [5:1] busy;
    logic [2:0] grant_id;
    logic       timeout;
    logic [2:0] timeout_id;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q[$];

    assign busy = {busy_5, busy_4, busy_3, busy_2, busy_1};

    busy_arbiter #(.SLOT_MAX(SLOT_MAX), .GAP(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_1      (req[1]),
        .req_2      (req[2]),
        .req_3      (req[3]),
        .req_4      (req[4]),
        .req_5      (req[5]),
        .done_1     (done[1]),
        .done_2     (done[2]),
        .done_3     (done[3]),
        .done_4     (done[4]),
        .done_5     (done[5]),
        .busy_1     (busy_1),
        .busy_2     (busy_2),
        .busy_3     (busy_3),
        .busy_4     (busy_4),
        .busy_5     (busy_5),
        .grant_id   (grant_id),
        .timeout    (timeout),
        .timeout_id (timeout_id),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        done  = '0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    // Wait for a grant to appear, then compare it with the scoreboard head.
    task automatic wait_grant(input int budget, output int waited, output logic [2:0] got);
        logic       found;
        logic [2:0] e;
        logic [5:1] eb;
        found  = 1'b0;
        waited = 0;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (grant_id != 3'd0) begin
                waited = c;
                found  = 1'b1;
                break;
            end
        end
        check("grant_arrived", 32'(found), 32'd1);
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            eb = '0;
            for (int i = 1; i <= 5; i++) if (i == int'(e)) eb[i] = 1'b1;
            check("grant_id", 32'(grant_id), 32'(e));
            check("busy_onehot", 32'(busy), 32'(eb));
        end
        got = grant_id;
    endtask

    // Hold the grant one cycle, then release it with done_k.
    task automatic release_grant(input logic [2:0] k);
        tick();
        if (k != 3'd0) done[k] = 1'b1;
        tick();
        done = '0;
        check("busy_drop", 32'(busy), 32'd0);
        check("grant_id_drop", 32'(grant_id), 32'd0);
    endtask

    // done_k lands on the same edge that samples counter == SLOT_MAX-1.
    task automatic coincide(input int k);
        int         w;
        logic [2:0] g;
        repeat (3) tick();
        req[k] = 1'b1;
        exp_q.push_back(3'(k));
        wait_grant(5, w, g);
        req[k] = 1'b0;
        repeat (SLOT_MAX - 1) tick();
        check("pre_limit_busy", 32'(busy[k]), 32'd1);
        done[k] = 1'b1;
        tick();
        done = '0;
        check("coincide_busy", 32'(busy), 32'd0);
        check("coincide_no_timeout", 32'(timeout), 32'd0);
        check("coincide_tid_hold", 32'(timeout_id), 32'd2);
        check("coincide_state_gap", 32'(dbg_state), 32'd2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int         w;
        int         n;
        logic [2:0] g;

        reset = 1'b0;
        req   = '0;
        done  = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_timeout_id", 32'(timeout_id), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // Single request, early release, one idle gap cycle.
        reset = 1'b1;
        tick();
        check("idle_no_grant", 32'(grant_id), 32'd0);
        req[3] = 1'b1;
        exp_q.push_back(3'd3);
        wait_grant(1, w, g);
        check("grant_latency", 32'(w), 32'd1);
        check("state_grant", 32'(dbg_state), 32'd1);
        req[3]  = 1'b0;
        done[1] = 1'b1;
        tick();
        done = '0;
        check("foreign_done_ignored", 32'(busy), 32'b00100);
        tick();
        done[3] = 1'b1;
        tick();
        done = '0;
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_state_gap", 32'(dbg_state), 32'd2);
        check("done_no_timeout", 32'(timeout), 32'd0);
        tick();
        check("gap_busy_low", 32'(busy), 32'd0);
        check("gap_to_idle", 32'(dbg_state), 32'd0);

        // Round-robin among word formers, 1,2,3,4,1 with GAP+1 low cycles.
        do_reset();
        req[4:1] = 4'b1111;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd1);
        for (int i = 0; i < 5; i++) begin
            wait_grant(10, w, g);
            if (i > 0) check("turnaround", 32'(w), 32'(GAP + 1));
            release_grant(g);
        end
        req = '0;

        // Slot limit: busy_2 high for SLOT_MAX cycles then timeout.
        do_reset();
        req[2] = 1'b1;
        exp_q.push_back(3'd2);
        wait_grant(5, w, g);
        n = 1;
        for (int c = 0; c < SLOT_MAX + 20; c++) begin
            tick();
            if (busy[2]) begin
                n++;
                check("no_early_timeout", 32'(timeout), 32'd0);
            end else begin
                break;
            end
        end
        check("slot_length", 32'(n), 32'(SLOT_MAX));
        check("timeout_pulse", 32'(timeout), 32'd1);
        check("timeout_id", 32'(timeout_id), 32'd2);
        req[2] = 1'b0;
        tick();
        check("timeout_one_cycle", 32'(timeout), 32'd0);
        check("timeout_id_held", 32'(timeout_id), 32'd2);

        // done_k together with the slot limit: treated as done.
        coincide(2);
        coincide(3);

        // Reset in the middle of a grant to client 4.
        repeat (3) tick();
        req[4] = 1'b1;
        exp_q.push_back(3'd4);
        wait_grant(5, w, g);
        repeat (5) tick();
        reset = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_grant_id", 32'(grant_id), 32'd0);
        check("midrst_timeout", 32'(timeout), 32'd0);
        check("midrst_timeout_id", 32'(timeout_id), 32'd0);
        reset  = 1'b1;
        req[1] = 1'b1;
        exp_q.push_back(3'd1);
        wait_grant(5, w, g);
        check("post_rst_latency", 32'(w), 32'd1);
        release_grant(g);
        req = '0;

        // MCM vs client 1 raised together.
        do_reset();
        req[1] = 1'b1;
        req[5] = 1'b1;
`ifdef BUSY_ARBITER_MCM_PRIORITY_EN
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd1);
`else
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd5);
`endif
        for (int i = 0; i < 2; i++) begin
            wait_grant(10, w, g);
            if (g != 3'd0) req[g] = 1'b0;
            release_grant(g);
        end
        req = '0;
        repeat (3) tick();
        check("final_idle", 32'(dbg_state), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
